// File: rtl/inv_sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_iter
//
// Iterative InvSubBytes stage of the AES-128 inverse cipher round. A 128-bit
// state is accepted from the InvShiftRows stage, BYTES_PER_CYCLE bytes are
// pushed through the FIPS-197 inverse S-box per clock, and the finished state
// is offered to the AddRoundKey stage. The same BYTES_PER_CYCLE lookup
// instances are reused for every chunk of the state.
//
// Parameters:
//   BYTES_PER_CYCLE  bytes substituted per clock (1, 2, 4, 8 or 16)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   state_in holds a valid state
//   in_ready   block can accept a state this cycle (IDLE only)
//   state_in   input state, byte i = state_in[127-8i -: 8]
//   out_valid  state_out holds the finished result (DONE only)
//   out_ready  downstream accepts state_out this cycle
//   state_out  inverse-substituted state, same byte ordering as state_in
//   busy       high while a state is being processed or awaiting hand-off
// -----------------------------------------------------------------------------
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NUM_CHUNKS = 16 / BYTES_PER_CYCLE;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // FIPS-197 inverse S-box, index 0x00 first.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // [0:15] ordering makes element i the byte at state_in[127-8i -: 8].
  logic [0:15][7:0] work_q, work_d;
  logic [3:0]       base;
  logic [7:0]       sub_out [BYTES_PER_CYCLE];

  // First byte of the chunk handled this cycle.
  assign base = 4'(int'(cnt_q) * BYTES_PER_CYCLE);

  generate
    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
      assign sub_out[b] = INV_SBOX[work_q[base + 4'(b)]];
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
          work_d[base + 4'(b)] = sub_out[b];
        end
        // Counter holds on the last chunk so it never wraps.
        if (cnt_q == LAST_CHUNK) state_d = ST_DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values. The working register is reset as well because it
  // drives state_out, which must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign state_out = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_iter
//
// Bench for inv_sub_bytes_iter. Five instances (BYTES_PER_CYCLE = 4, 1, 2, 8,
// 16) share clock and reset. Expected data comes from an inverse S-box derived
// arithmetically (inverse affine map followed by GF(2^8) inversion).
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_iter;

  localparam int NI = 5;
  localparam int BPC_TAB [NI] = '{4, 1, 2, 8, 16};

  logic         clk;
  logic         rst_n;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [127:0] st_in     [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] st_out    [NI];
  logic         busy      [NI];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] ref_tab [256];

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      inv_sub_bytes_iter #(.BYTES_PER_CYCLE(BPC_TAB[g])) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .state_in (st_in[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .state_out(st_out[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic build_ref();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      logic [7:0] inv;
      v   = 8'(x);
      v   = rotl8(v, 1) ^ rotl8(v, 3) ^ rotl8(v, 6) ^ 8'h05;
      inv = 8'h00;
      if (v != 8'h00)
        for (int y = 1; y < 256; y++)
          if (gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
      ref_tab[x] = inv;
    end
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] din);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_tab[din[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers din to unit idx (called at a negedge while idle) and returns at the
  // first negedge with out_valid high; lat = clock edges after acceptance.
  task automatic transact(input int idx, input logic [127:0] din,
                          output logic [127:0] dout, output int lat);
    in_valid[idx] = 1'b1;
    st_in[idx]    = din;
    @(posedge clk);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    st_in[idx]    = rand128();
    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    dout = st_out[idx];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; st_in[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      total_cnt++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0) begin
        $display("FAIL reset_ctrl[%0d]: got in_ready=%b out_valid=%b busy=%b, expected 1 0 0",
                 i, in_ready[i], out_valid[i], busy[i]);
      end else pass_cnt++;
      total_cnt++;
      if (st_out[i] !== 128'h0) $display("FAIL reset_data[%0d]: got %h expected 0", i, st_out[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_all_63();
    logic [127:0] dout;
    int lat;
    out_ready[0] = 1'b1;
    transact(0, {16{8'h63}}, dout, lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL all63_latency: got %0d expected 4", lat); else pass_cnt++;
    total_cnt++;
    if (dout !== 128'h0) $display("FAIL all63_data: got %h expected 0", dout); else pass_cnt++;
    total_cnt++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0)
      $display("FAIL all63_done_flags: got busy=%b in_ready=%b expected 1 0", busy[0], in_ready[0]);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0)
      $display("FAIL all63_return_idle: got in_ready=%b out_valid=%b expected 1 0",
               in_ready[0], out_valid[0]);
    else pass_cnt++;
  endtask

  task automatic test_known_vector();
    logic [127:0] dout;
    int lat;
    out_ready[0] = 1'b1;
    transact(0, 128'h637c_0016_5300_0000_0000_0000_0000_0000, dout, lat);
    total_cnt++;
    if (dout !== 128'h0001_52ff_5052_5252_5252_5252_5252_5252)
      $display("FAIL known_vector: got %h expected 000152ff505252525252525252525252", dout);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] din, dout, hold;
    int lat;
    din = rand128();
    out_ready[0] = 1'b0;
    transact(0, din, dout, lat);
    hold = dout;
    total_cnt++;
    if (dout !== ref_state(din)) $display("FAIL bp_data: got %h expected %h", dout, ref_state(din));
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      in_valid[0] = c[0];
      st_in[0]    = rand128();
      @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || st_out[0] !== hold)
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b data=%h expected 1 0 %h",
                 c, out_valid[0], in_ready[0], st_out[0], hold);
      else pass_cnt++;
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               out_valid[0], in_ready[0], busy[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] dout;
    int lat;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    st_in[0]     = rand128();
    @(posedge clk);          // acceptance
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);          // two chunks done
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL midbusy_reset: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               out_valid[0], in_ready[0], busy[0]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transact(0, 128'h0, dout, lat);
    total_cnt++;
    if (dout !== {16{8'h52}} || lat !== 4)
      $display("FAIL midbusy_fresh: got %h lat %0d expected all-52 lat 4", dout, lat);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random_sweep();
    logic [127:0] din, dout;
    int lat;
    for (int idx = 0; idx < NI; idx++) begin
      out_ready[idx] = 1'b1;
      for (int n = 0; n < 100; n++) begin
        din = rand128();
        transact(idx, din, dout, lat);
        total_cnt++;
        if (dout !== ref_state(din))
          $display("FAIL sweep_data bpc=%0d #%0d: got %h expected %h",
                   BPC_TAB[idx], n, dout, ref_state(din));
        else pass_cnt++;
        total_cnt++;
        if (lat !== 16 / BPC_TAB[idx])
          $display("FAIL sweep_latency bpc=%0d #%0d: got %0d expected %0d",
                   BPC_TAB[idx], n, lat, 16 / BPC_TAB[idx]);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] din;
    int rises[$];
    int cyc;
    logic prev;
    din = rand128();
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    st_in[0]     = din;
    prev = 1'b0;
    cyc  = 0;
    while (rises.size() < 2 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid[0] === 1'b1 && prev !== 1'b1) begin
        rises.push_back(cyc);
        total_cnt++;
        if (st_out[0] !== ref_state(din))
          $display("FAIL b2b_data: got %h expected %h", st_out[0], ref_state(din));
        else pass_cnt++;
      end
      prev = out_valid[0];
    end
    in_valid[0] = 1'b0;
    total_cnt++;
    if (rises.size() != 2 || rises[1] - rises[0] != 6)
      $display("FAIL b2b_period: got %0d results, spacing %0d, expected 2 results spacing 6",
               rises.size(), (rises.size() == 2) ? rises[1] - rises[0] : -1);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    build_ref();
    test_reset();
    test_all_63();
    test_known_vector();
    test_backpressure();
    test_reset_mid_busy();
    test_random_sweep();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
